// File: rtl/field_pkg.sv
// Shared definitions for the mod (2^61-1) field datapath: element width,
// modulus and the per-bank collector state.
package field_pkg;

    localparam int F_NBITS = 61;

    typedef logic [F_NBITS-1:0] felem_t;

    localparam felem_t P = {F_NBITS{1'b1}};

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } bank_state_e;

endpackage

// File: rtl/field_add_modp.sv
// Combinational two-operand add modulo 2^61-1 for operands no larger than the modulus.
// The result is always strictly below the modulus.
module field_add_modp
    import field_pkg::*;
(
    input  felem_t a,
    input  felem_t b,
    output felem_t sum
);

    logic [F_NBITS:0] s;
    felem_t           t;

    // 2^61 == 1 mod p, so the carry folds back into bit 0; t can land exactly on p.
    assign s   = {1'b0, a} + {1'b0, b};
    assign t   = s[F_NBITS-1:0] + felem_t'(s[F_NBITS]);
    assign sum = (t == P) ? '0 : t;

endmodule

// File: rtl/v_parts_collect.sv
// Double-buffered collector: accumulates serial per-gate contributions mod p
// into ngates slots and presents a full bank as v_parts with valid/ack.
module v_parts_collect
    import field_pkg::*;
#(
    parameter int ngates = 8,
    parameter int gnbits = $clog2(ngates)
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      in_en,
    input  logic [gnbits-1:0]         in_idx,
    input  felem_t                    in_val,
    input  logic                      in_last,
    output logic                      in_ready,
    output felem_t [ngates-1:0]       v_parts,
    output logic                      out_valid,
    input  logic                      out_ack,
    output logic                      err_idx,
    output logic                      err_ovf
);

    felem_t              slots [2][ngates];
    bank_state_e         bank_st [2];
    logic                wr_bank;
    logic                rd_bank;
    logic [ngates-1:0]   idx_match;
    felem_t              cur_slot;
    felem_t              sum;
    logic                idx_hit;
    logic                accept;
    logic                close_frame;
    logic                release_frame;

    assign in_ready      = (bank_st[wr_bank] == FILL);
    assign out_valid     = (bank_st[rd_bank] == FULL);
    assign accept        = in_en & in_ready;
    assign close_frame   = accept & in_last;
    assign release_frame = out_valid & out_ack;
    assign idx_hit       = |idx_match;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        idx_match = '0;
        cur_slot  = '0;
        for (int g = 0; g < ngates; g++) begin
            if (in_idx == gnbits'(g)) begin
                idx_match[g] = 1'b1;
                cur_slot     = slots[wr_bank][g];
            end
        end
    end

    field_add_modp u_add (
        .a   (cur_slot),
        .b   (in_val),
        .sum (sum)
    );

    for (genvar g = 0; g < ngates; g++) begin : g_out
        assign v_parts[g] = slots[rd_bank][g];
    end

    // The FULL bank being acked is never the FILL bank being written, so the
    // clear and the accumulate below cannot collide on one bank.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            // NOTE: the slot array is plain registers, not a RAM, so it is reset
            // like any other state; a reset must discard every partial frame.
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= FILL;
                for (int g = 0; g < ngates; g++) begin
                    slots[b][g] <= '0;
                end
            end
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            err_idx <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only, so every
            // read in this block sees the pre-edge value.
            for (int b = 0; b < 2; b++) begin
                for (int g = 0; g < ngates; g++) begin
                    if (release_frame && rd_bank == 1'(b)) begin
                        slots[b][g] <= '0;
                    end else if (accept && wr_bank == 1'(b) && idx_match[g]) begin
                        slots[b][g] <= sum;
                    end
                end
            end
            if (release_frame) begin
                bank_st[rd_bank] <= FILL;
                rd_bank          <= ~rd_bank;
            end
            if (close_frame) begin
                bank_st[wr_bank] <= FULL;
                wr_bank          <= ~wr_bank;
            end
            if (accept && !idx_hit) begin
                err_idx <= 1'b1;
            end
            if (in_en && !in_ready) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_v_parts_collect.sv
// Self-checking bench for v_parts_collect: directed table, hand-written corner
// sequences and randomized traffic against a frame-queue reference model.
module tb_v_parts_collect;
    import field_pkg::*;

    localparam int NG  = 8;
    localparam int GB  = 3;
    localparam int NG2 = 10;
    localparam int GB2 = 4;
    localparam logic [63:0] P64 = 64'h1FFF_FFFF_FFFF_FFFF;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    logic                in_en, in_last, out_ack;
    logic [GB-1:0]       in_idx;
    felem_t              in_val;
    logic                in_ready, out_valid, err_idx, err_ovf;
    felem_t [NG-1:0]     v_parts;

    logic                in_en2, in_last2, out_ack2;
    logic [GB2-1:0]      in_idx2;
    felem_t              in_val2;
    logic                in_ready2, out_valid2, err_idx2, err_ovf2;
    felem_t [NG2-1:0]    v_parts2;

    v_parts_collect #(.ngates(NG), .gnbits(GB)) dut (
        .clk(clk), .rstb(rstb), .in_en(in_en), .in_idx(in_idx), .in_val(in_val),
        .in_last(in_last), .in_ready(in_ready), .v_parts(v_parts),
        .out_valid(out_valid), .out_ack(out_ack), .err_idx(err_idx), .err_ovf(err_ovf)
    );

    v_parts_collect #(.ngates(NG2), .gnbits(GB2)) dut2 (
        .clk(clk), .rstb(rstb), .in_en(in_en2), .in_idx(in_idx2), .in_val(in_val2),
        .in_last(in_last2), .in_ready(in_ready2), .v_parts(v_parts2),
        .out_valid(out_valid2), .out_ack(out_ack2), .err_idx(err_idx2), .err_ovf(err_ovf2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: completed frames wait in a queue (two banks => at most two),
    // the frame under construction is a plain array summed with % p.
    typedef logic [63:0] frame_t [NG];
    frame_t done_q[$];
    frame_t cur;
    bit     m_eidx, m_eovf;

    function automatic void model_reset();
        done_q.delete();
        foreach (cur[i]) cur[i] = 0;
        m_eidx = 0;
        m_eovf = 0;
    endfunction

    function automatic void model_step(input bit en, input int idx, input logic [63:0] val,
                                       input bit last, input bit ack);
        bit ready = (done_q.size() < 2);
        bit rel   = (done_q.size() > 0) && ack;
        if (en && !ready) m_eovf = 1;
        if (rel) done_q.delete(0);
        if (en && ready) begin
            if (idx < NG) cur[idx] = (cur[idx] + val) % P64;
            else          m_eidx = 1;
            if (last) begin
                done_q.push_back(cur);
                foreach (cur[i]) cur[i] = 0;
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        logic [63:0] exp;
        check({tag, " in_ready"},  64'(in_ready),  64'(done_q.size() < 2));
        check({tag, " out_valid"}, 64'(out_valid), 64'(done_q.size() > 0));
        check({tag, " err_idx"},   64'(err_idx),   64'(m_eidx));
        check({tag, " err_ovf"},   64'(err_ovf),   64'(m_eovf));
        for (int i = 0; i < NG; i++) begin
            exp = (done_q.size() > 0) ? done_q[0][i] : cur[i];
            check($sformatf("%s slot%0d", tag, i), 64'(v_parts[i]), exp);
        end
    endtask

    task automatic cycle(input bit en, input int idx, input logic [63:0] val,
                         input bit last, input bit ack, input string tag);
        in_en   = en;
        in_idx  = idx[GB-1:0];
        in_val  = val[F_NBITS-1:0];
        in_last = last;
        out_ack = ack;
        model_step(en, idx, val, last, ack);
        @(posedge clk);
        #1;
        compare_all(tag);
        in_en   = 1'b0;
        in_last = 1'b0;
        out_ack = 1'b0;
    endtask

    typedef struct {
        bit          en;
        int          idx;
        logic [63:0] val;
        bit          last;
        bit          ack;
        bit          exp_ready;
        bit          exp_valid;
        int          chk_idx;
        logic [63:0] chk_val;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_en = 0; in_idx = 0; in_val = 0; in_last = 0; out_ack = 0;
        in_en2 = 0; in_idx2 = 0; in_val2 = 0; in_last2 = 0; out_ack2 = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        check("reset dut2 in_ready", 64'(in_ready2), 64'd1);
        check("reset dut2 out_valid", 64'(out_valid2), 64'd0);
        @(negedge clk);
        rstb = 1'b1;

        // Out-of-range index on the 10-slot instance: flagged, frame closes empty.
        in_en2 = 1; in_idx2 = 4'd12; in_val2 = 61'd7; in_last2 = 1;
        cycle(0, 0, 0, 0, 0, "idx_err idle");
        in_en2 = 0; in_last2 = 0;
        check("idx_err err_idx", 64'(err_idx2), 64'd1);
        check("idx_err out_valid", 64'(out_valid2), 64'd1);
        check("idx_err in_ready", 64'(in_ready2), 64'd1);
        for (int i = 0; i < NG2; i++)
            check($sformatf("idx_err slot%0d", i), 64'(v_parts2[i]), 64'd0);
        in_en2 = 1; in_idx2 = 4'd9; in_val2 = 61'd7; out_ack2 = 1;
        cycle(0, 0, 0, 0, 0, "idx_ok idle");
        in_en2 = 0; out_ack2 = 0;
        check("idx_ok out_valid", 64'(out_valid2), 64'd0);
        check("idx_ok slot9", 64'(v_parts2[9]), 64'd7);

        // Table: full frame 1..8, then repeated hits on slot 3 wrapping past p.
        for (int i = 0; i < NG; i++)
            tbl.push_back(vec_t'{1'b1, i, 64'(i + 1), (i == NG - 1), 1'b0, 1'b1, (i == NG - 1), i, 64'(i + 1)});
        tbl.push_back(vec_t'{1'b0, 0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 7, 64'd0});
        tbl.push_back(vec_t'{1'b1, 3, P64 - 1, 1'b0, 1'b0, 1'b1, 1'b0, 3, P64 - 1});
        tbl.push_back(vec_t'{1'b1, 3, 64'd5, 1'b0, 1'b0, 1'b1, 1'b0, 3, 64'd4});
        tbl.push_back(vec_t'{1'b1, 3, 64'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3, 64'd6});
        tbl.push_back(vec_t'{1'b0, 0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 64'd0});
        foreach (tbl[k]) begin
            cycle(tbl[k].en, tbl[k].idx, tbl[k].val, tbl[k].last, tbl[k].ack, $sformatf("tbl%0d", k));
            check($sformatf("tbl%0d ready", k), 64'(in_ready), 64'(tbl[k].exp_ready));
            check($sformatf("tbl%0d valid", k), 64'(out_valid), 64'(tbl[k].exp_valid));
            check($sformatf("tbl%0d slot", k), 64'(v_parts[tbl[k].chk_idx]), tbl[k].chk_val);
        end

        // Two frames without ack, then an overflow beat, then release.
        cycle(1, 0, 64'd11, 0, 0, "ovf a0");
        cycle(1, 1, 64'd22, 1, 0, "ovf a1");
        cycle(1, 2, 64'd33, 1, 0, "ovf b2");
        check("ovf ready low", 64'(in_ready), 64'd0);
        cycle(1, 5, 64'd99, 1, 0, "ovf drop");
        check("ovf flag", 64'(err_ovf), 64'd1);
        check("ovf keep a1", 64'(v_parts[1]), 64'd22);
        cycle(0, 0, 0, 0, 1, "ovf ack a");
        check("ovf b shown", 64'(v_parts[2]), 64'd33);
        check("ovf b valid", 64'(out_valid), 64'd1);
        check("ovf ready back", 64'(in_ready), 64'd1);
        cycle(0, 0, 0, 0, 1, "ovf ack b");

        // Ack of frame A in the same cycle as frame B's last beat.
        cycle(1, 4, 64'd100, 1, 0, "sim a");
        cycle(1, 6, 64'd200, 0, 0, "sim b0");
        cycle(1, 6, 64'd1, 1, 1, "sim b1+ack");
        check("sim valid", 64'(out_valid), 64'd1);
        check("sim b slot6", 64'(v_parts[6]), 64'd201);
        check("sim a gone", 64'(v_parts[4]), 64'd0);
        check("sim ready", 64'(in_ready), 64'd1);
        cycle(0, 0, 0, 0, 1, "sim ack b");

        // Reset mid-frame, then a clean frame.
        for (int i = 0; i < 4; i++) cycle(1, i, 64'd5, 0, 0, "mid");
        #2;
        rstb = 1'b0;
        model_reset();
        #1;
        compare_all("mid reset");
        @(negedge clk);
        rstb = 1'b1;
        for (int i = 0; i < NG; i++) cycle(1, i, 64'(1000 + i), (i == NG - 1), 0, "post");
        check("post slot0", 64'(v_parts[0]), 64'd1000);
        cycle(0, 0, 0, 0, 1, "post ack");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] r;
            int sel;
            r   = {$urandom, $urandom} & P64;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) r = P64;
            if (sel == 1) r = P64 - 1;
            cycle(($urandom_range(0, 9) < 7), int'($urandom_range(0, NG - 1)), r,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                  $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
